// File: rtl/spi_cmd_rx.sv
// spi_cmd_rx: SPI mode-0 slave that deserialises CMD+DATA frames into words and pulses cmd_valid.
// Define SPI_MISO_ECHO_EN to echo the previous frame on spi_miso during the current one.
module spi_cmd_rx #(
  parameter int CMD_WIDTH      = 8,
  parameter int DATAWORD_WIDTH = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      spi_sclk,
  input  logic                      spi_cs_n,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  output logic [CMD_WIDTH-1:0]      cmd_word,
  output logic [DATAWORD_WIDTH-1:0] data_word,
  output logic                      cmd_valid,
  output logic                      busy,
  output logic                      frame_err
);
  localparam int F  = CMD_WIDTH + DATAWORD_WIDTH;
  localparam int CW = $clog2(F + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
  logic sclk_s, cs_s, mosi_s, sclk_h, cs_h, rise_q, bit_q;
  logic sclk_rise, cs_rise, full, short_end;
  logic [CW-1:0] cnt;
  logic [F-1:0] sr;
  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign cs_s      = cs_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_h & ~cs_s;
  assign cs_rise   = cs_s & ~cs_h;
  assign full      = state == SHIFT && cnt == CW'(F);
  assign short_end = state == SHIFT && !full && cs_rise && cnt != '0;
  assign busy      = ~cs_s;
  always_comb begin
    state_nx = state == IDLE  ? (cs_s ? IDLE : SHIFT)
             : state == SHIFT ? (full ? DONE : cs_rise ? IDLE : SHIFT)
             : (cs_s ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  // Rise detect is registered once more, so the shift lands SYNC_STAGES+1 edges after the pin edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q    <= '0;
      cs_q      <= '1;
      mosi_q    <= '0;
      sclk_h    <= 1'b0;
      cs_h      <= 1'b1;
      rise_q    <= 1'b0;
      bit_q     <= 1'b0;
      cnt       <= '0;
      sr        <= '0;
      cmd_word  <= '0;
      data_word <= '0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sclk_q    <= {sclk_q[SYNC_STAGES-2:0], spi_sclk};
      cs_q      <= {cs_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_q    <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_h    <= sclk_s;
      cs_h      <= cs_s;
      rise_q    <= sclk_rise;
      bit_q     <= mosi_s;
      cmd_valid <= full;
      frame_err <= short_end;
      if (state == IDLE) begin
        cnt <= '0;
        sr  <= '0;
      end else if (state == SHIFT && rise_q && !full) begin
        cnt <= cnt + CW'(1);
        sr  <= {sr[F-2:0], bit_q};
      end
      if (full) {cmd_word, data_word} <= sr;
    end
  end
`ifdef SPI_MISO_ECHO_EN
  logic [F-1:0] tx;
  logic sclk_fall;
  assign sclk_fall = ~sclk_s & sclk_h;
  assign spi_miso  = state == SHIFT && tx[F-1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx <= '0;
    else if (state == IDLE && !cs_s) tx <= {cmd_word, data_word};
    else if (state == SHIFT && sclk_fall) tx <= {tx[F-2:0], 1'b0};
  end
`else
  assign spi_miso = 1'b0;
`endif
endmodule

// File: tb/tb_spi_cmd_rx.sv
// tb_spi_cmd_rx: randomized and directed frames checked against a frame-level model of spi_cmd_rx.
`timescale 1ns/1ps
module tb_spi_cmd_rx;
  localparam int CW = 8, DW = 16, SS = 2, F = CW + DW;
  logic clk, rst, spi_sclk, spi_cs_n, spi_mosi, spi_miso, cmd_valid, busy, frame_err;
  logic [CW-1:0] cmd_word;
  logic [DW-1:0] data_word;
  int vec = 0, miscompares = 0;
  int nv = 0, ne = 0, bad = 0, exp_nv = 0, exp_ne = 0;
  longint t_rise = 0, t_valid = 0;
  logic [CW-1:0] exp_c = '0, prev_c = '0;
  logic [DW-1:0] exp_d = '0, prev_d = '0;
  logic [F-1:0] miso_cap;

  spi_cmd_rx #(.CMD_WIDTH(CW), .DATAWORD_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .cmd_word(cmd_word), .data_word(data_word), .cmd_valid(cmd_valid),
    .busy(busy), .frame_err(frame_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (cmd_valid) begin
        nv++;
        t_valid = $time;
      end else if (cmd_word !== prev_c || data_word !== prev_d) bad++;
      if (frame_err) ne++;
    end
    prev_c = cmd_word;
    prev_d = data_word;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
    check("valid_count", nv, exp_nv);
    check("err_count", ne, exp_ne);
    check("word_hold", bad, 0);
  endtask

  // Send n bits (MSB = bits[n-1]) with sclk half-period in clk cycles, then hold cs_n high for gap clks.
  task automatic send_frame(input logic [63:0] bits, input int n, input int half, input int gap);
    logic [F-1:0] prev;
    prev = {exp_c, exp_d};
    miso_cap = '0;
    spi_cs_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      spi_mosi = bits[n-1-i];
      repeat (half) @(negedge clk);
      if (i < F) miso_cap = {miso_cap[F-2:0], spi_miso};
      if (i == F - 1) t_rise = $time;
      if (i == n / 2) check("busy_in_frame", busy, 1);
      spi_sclk = 1'b1;
      repeat (half) @(negedge clk);
      spi_sclk = 1'b0;
    end
    repeat (half) @(negedge clk);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (gap) @(negedge clk);
    if (n >= F) begin
      {exp_c, exp_d} = bits[n-1 -: F];
      exp_nv++;
    end else if (n > 0) exp_ne++;
    check("cmd_word", cmd_word, exp_c);
    check("data_word", data_word, exp_d);
`ifdef SPI_MISO_ECHO_EN
    if (n >= F && half >= 4) check("miso_echo", miso_cap, prev);
`else
    check("miso_zero", miso_cap, 0);
`endif
  endtask

  initial begin
    logic [63:0] r;
    int n;
    rst = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    @(posedge clk); #1;
    check("rst_cmd", cmd_word, 0);
    check("rst_data", data_word, 0);
    check("rst_valid", cmd_valid, 0);
    check("rst_err", frame_err, 0);
    check("rst_busy", busy, 0);
    check("rst_miso", spi_miso, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send_frame(64'h5AC3C3, F, 4, 6);
    send_frame(64'h821234, F, 4, 6);
    settle();
    // reset in the middle of a frame
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      spi_mosi = i[0];
      repeat (3) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (3) @(negedge clk);
      spi_sclk = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    check("midrst_cmd", cmd_word, 0);
    check("midrst_data", data_word, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", frame_err, 0);
    exp_c = '0;
    exp_d = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_after_rst", busy, 1);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    settle();
    send_frame(64'h821234, F, 4, 6);
    settle();
    send_frame(64'h0100FF, F, 4, 2);
    send_frame(64'h20ABCD, F, 4, 6);
    settle();
    send_frame(64'h1A5B, 13, 4, 6);
    settle();
    send_frame({34'd0, 24'hFFFFFF, 6'h15}, 30, 4, 6);
    settle();
    for (int i = 0; i < 5; i++) begin
      spi_sclk = 1'b1;
      repeat (2) @(negedge clk);
      spi_sclk = 1'b0;
      repeat (2) @(negedge clk);
    end
    check("idle_sclk_busy", busy, 0);
    settle();
    send_frame(64'h3C9E17, F, 2, 6);
    check("latency", 32'(t_valid - t_rise), 32'(5 + (SS + 2) * 10 + 1));
    settle();
    for (int k = 0; k < 10; k++) begin
      r = {$urandom, $urandom};
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, F - 1) : F + $urandom_range(0, 4);
      send_frame(r, n, 4, $urandom_range(2, 6));
    end
    settle();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
    $finish;
  end
endmodule

// File: doc/spi_cmd_rx.md
Name: spi_cmd_rx

Overview:
SPI slave front end that deserialises command frames from the external SPI pins into a command word and a data word, then pulses cmd_valid for one clk. It sits directly upstream of the command decoder and drives that block's cmd_word, data_word and cmd_valid inputs. All SPI pins are asynchronous to clk and are oversampled through synchronisers.

Parameters:
CMD_WIDTH, 8, width of command field (first bits of frame)
DATAWORD_WIDTH, 16, width of data field (follows command field)
SYNC_STAGES, 2, flip-flop stages on each SPI input synchroniser (min 2)

Ports:
clk  input  1  system clock; f_clk >= 4 x f_sclk required
rst  input  1  asynchronous, active-high reset
spi_sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
spi_cs_n  input  1  SPI chip select, active low, frames a transfer
spi_mosi  input  1  serial data in, MSB first
spi_miso  output  1  serial data out (see Optional Feature)
cmd_word  output  CMD_WIDTH  last complete frame command field
data_word  output  DATAWORD_WIDTH  last complete frame data field
cmd_valid  output  1  one-clk pulse, cmd_word/data_word newly valid
busy  output  1  high while synchronised cs_n is low
frame_err  output  1  one-clk pulse, frame ended short

Behaviour:
- Frame length F = CMD_WIDTH + DATAWORD_WIDTH (24 default). Bits MSB first; first CMD_WIDTH bits -> cmd_word, remaining -> data_word.
- Synchronisers: sclk, cs_n, mosi each pass SYNC_STAGES flops, plus one history flop on sclk and cs_n. sclk rise = sync & ~hist; cs fall/rise likewise. mosi sampled from its synchronised copy on the clk where sclk rise is detected (same stage depth, so aligned).
- Reset (async, rst=1): all sync flops to idle levels (sclk 0, cs_n 1, mosi 0); state IDLE; bit counter 0; shift reg 0; cmd_word 0; data_word 0; cmd_valid 0; frame_err 0; busy 0; spi_miso 0.
- FSM:
  IDLE: on synchronised cs_n low -> SHIFT, clear bit counter and shift reg.
  SHIFT: each sclk rise shifts mosi into LSB, counter++. When counter reaches F (the F-th rise), next clk: cmd_word/data_word load from shift reg, cmd_valid=1 for exactly one clk, -> DONE. If cs_n rises with 0 < counter < F: frame_err=1 one clk, outputs unchanged, -> IDLE. cs_n rise with counter 0: -> IDLE silently, no pulse.
  DONE: sclk rises ignored (extra bits discarded, no second cmd_valid). cs_n rise -> IDLE.
- Latency: cmd_valid asserted SYNC_STAGES+2 clk edges after the clk edge that first sees the F-th sclk rising edge at the synchroniser input.
- cmd_word/data_word hold their value until the next complete frame; never change except on the cmd_valid cycle.
- busy = synchronised cs_n inverted (not tied to FSM state).
- cs_n fall while in SHIFT/DONE is impossible without rise first; cs_n glitch shorter than one clk may be missed, no requirement.
- sclk edges while cs_n high are ignored in every state.
- rst mid-frame: partial frame discarded, outputs back to reset values; no frame_err.
- Back-to-back frames: cs_n high for >= 2 clk between frames is sufficient; each complete frame gives exactly one cmd_valid.

Optional Feature:
SPI_MISO_ECHO_EN. Defined: a transmit shift register loads {cmd_word, data_word} of the previous complete frame when the FSM enters SHIFT; spi_miso drives its MSB and shifts left on each detected sclk falling edge while in SHIFT, so the master reads back the previous frame during the current one; spi_miso = 0 in IDLE/DONE. Undefined: spi_miso is constant 0, no transmit register, no sclk fall detector.

Test Plan:
- Reset: rst=1 mid-operation -> all outputs 0 within same cycle, state IDLE; after release, a 24-bit frame 0x82_1234 -> cmd_word=0x82, data_word=0x1234, cmd_valid one clk.
- Back-to-back frames 0x01_00FF then 0x20_ABCD, cs_n high 2 clk between -> exactly two cmd_valid pulses, values in order; data_word holds 0x00FF between them.
- Short frame: 13 bits then cs_n high -> frame_err one clk, no cmd_valid, cmd_word/data_word keep prior 0x20/0xABCD.
- Long frame: 30 bits, first 24 = 0xFF_FFFF -> one cmd_valid after bit 24, outputs 0xFF/0xFFFF, trailing 6 bits ignored, no frame_err.
- sclk toggling with cs_n high (10 edges) -> no cmd_valid, no frame_err, busy 0; latency check: cmd_valid exactly SYNC_STAGES+2 clk after 24th sclk rise at pins, f_sclk = f_clk/4.
- SPI_MISO_ECHO_EN: send 0x5A_C3C3 then any frame -> spi_miso bits during second frame read 0x5AC3C3 MSB first; without macro spi_miso stays 0 throughout.
